seg7_scan: RTL

Four-digit multiplexed seven-segment display driver for the Basys2 common-anode display. It consumes the BCD digit pairs produced by the team's BCD time counters, such as the mod-24 hour counter and the mod-60 minute/second counters. It time-multiplexes those digits onto the shared segment bus, and supports per-digit decimal points, per-digit blinking (for time-set mode) and leading-zero blanking.

---
 rtl/seg7_scan.sv | 123 ++++++++++++
 1 files changed

// File: rtl/seg7_scan.sv
// Four-digit multiplexed common-anode seven-segment driver with per-digit decimal
// points, blink mask and leading-zero blanking. All outputs are registered.
module seg7_scan #(
  parameter int unsigned DIV          = 50000,
  parameter int unsigned BLINK_FRAMES = 125
) (
  input  logic       clk,
  input  logic       cr,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic [3:0] dp_in,
  input  logic [3:0] blink,
  input  logic       lz_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PLast = PW'(DIV - 1);
  localparam logic [FW-1:0] FLast = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          bphase_q, bphase_d;
  logic          wrap_q, wrap_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tick_q, tick_d;

  logic [3:0]    digit;
  logic          blank;

  // Scan counters: prescaler, digit index, frame counter and blink phase.
  always_comb begin
    pcnt_d   = pcnt_q + 1'b1;
    idx_d    = idx_q;
    fcnt_d   = fcnt_q;
    bphase_d = bphase_q;
    wrap_d   = 1'b0;
    if (pcnt_q == PLast) begin
      pcnt_d = '0;
      idx_d  = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        wrap_d = 1'b1;
        if (fcnt_q == FLast) begin
          fcnt_d   = '0;
          bphase_d = ~bphase_q;
        end else begin
          fcnt_d = fcnt_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    digit = d0;
    unique case (idx_q)
      2'd0: digit = d0;
      2'd1: digit = d1;
      2'd2: digit = d2;
      2'd3: digit = d3;
      default: digit = d0;
    endcase

    blank = (blink[idx_q] & bphase_q) | ((idx_q == 2'd3) & lz_en & (d3 == 4'd0));

    case (digit)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b0111111;
    endcase

    an_d   = blank ? 4'b1111 : ~(4'b0001 << idx_q);
    dp_d   = ~dp_in[idx_q];
    // wrap_q marks the edge that moved idx 3->0, so the pulse lines up with digit 0.
    tick_d = wrap_q;
  end

  always_ff @(posedge clk) begin
    if (!cr) begin
      pcnt_q   <= '0;
      idx_q    <= 2'd0;
      fcnt_q   <= '0;
      bphase_q <= 1'b0;
      wrap_q   <= 1'b0;
      an_q     <= 4'b1111;
      seg_q    <= 7'b1111111;
      dp_q     <= 1'b1;
      tick_q   <= 1'b0;
    end else begin
      pcnt_q   <= pcnt_d;
      idx_q    <= idx_d;
      fcnt_q   <= fcnt_d;
      bphase_q <= bphase_d;
      wrap_q   <= wrap_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      tick_q   <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule
